fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
// - Control sequencer for an iterative radix-2 DIT FFT that time-shares one pipelined FFT_Calc butterfly.
// - Walks log2(BUFFER_SIZE) stages of BUFFER_SIZE/2 butterflies each.
// - Issues per butterfly: operand read addresses, twiddle ROM index and delayed write-back addresses.
// - Sits between the in-place sample RAM (already holding bit-reversed input), the twiddle ROM and the butterfly.
// PARAMETERS
// - BUFFER_SIZE   32  FFT points; power of two, >= 4
// - BFLY_LATENCY  2   cycles from rd_en to butterfly results at RAM write port; >= 1
// - ADDR_W        $clog2(BUFFER_SIZE)  sample address width (derived)
// - STAGE_W       $clog2(ADDR_W)+1     stage counter width (derived)
// PORTS
// - clk        in   1        single clock, rising edge
// - rst        in   1        asynchronous, active-high reset
// - start      in   1        request transform; sampled only in IDLE
// - in_ready   in   1        RAM/ROM can accept a read this cycle; low = stall issue
// - busy       out  1        high from cycle after start accepted until done
// - done       out  1        one-cycle pulse, transform complete
// - stage      out  STAGE_W  current stage 0..ADDR_W-1
// - rd_en      out  1        read/issue strobe for one butterfly
// - rd_addr_a  out  ADDR_W   even operand address
// - rd_addr_b  out  ADDR_W   odd operand address
// - tw_addr    out  ADDR_W-1 twiddle ROM index, W_N^tw_addr
// - wr_en      out  1        write-back strobe
// - wr_addr_a  out  ADDR_W   sum-term destination, = issued rd_addr_a
// - wr_addr_b  out  ADDR_W   diff-term destination, = issued rd_addr_b
// BEHAVIOUR
// - Reset (async): state=IDLE; all outputs 0; counters and write-back pipe cleared.
// - Address generation, stage s, butterfly index k in 0..N/2-1:
//   - span = 1<<s; pos = k & (span-1); grp = k >> s
//   - rd_addr_a = grp*2*span + pos; rd_addr_b = rd_addr_a + span
//   - tw_addr = pos << (ADDR_W-1-s)
//   - All arithmetic is unsigned, truncated to the port width.
// - IDLE: start=1 -> ISSUE with s=0, k=0; busy=1 from next cycle. start=0 -> stay.
// - ISSUE:
//   - rd_en = in_ready. On an issue cycle k increments.
//   - in_ready=0: rd_en=0 and k/s hold; the write-back pipe keeps shifting (bubble).
//   - Issuing k=N/2-1 -> DRAIN.
// - DRAIN:
//   - rd_en=0; wait until the write-back pipe is empty (no wr_en pending in flight).
//   - Then s<ADDR_W-1 -> s++, k=0, ISSUE; else -> DONE.
//   - Purpose: a stage never reads data the previous stage has not yet written.
// - DONE: done=1, busy=0 for exactly one cycle -> IDLE.
// - Write-back pipe:
//   - BFLY_LATENCY-deep shift register of {valid, addr_a, addr_b}.
//   - wr_en/wr_addr_* equal the rd_en/rd_addr_* of exactly BFLY_LATENCY cycles earlier.
// - start while busy or in DONE: ignored, no queuing.
// - stage output holds s; it is 0 in IDLE.
// - Mid-operation rst: immediate return to IDLE, outputs 0, in-flight writes discarded; the RAM contents are then undefined.
// - No-stall cycle count:
//   - busy lasts ADDR_W*(N/2 + BFLY_LATENCY) cycles; done follows in the next cycle.
//   - In-ready stalls add one cycle each.
// TESTING (BUFFER_SIZE=8, BFLY_LATENCY=2 unless noted)
// - Reset: rst=1 mid-ISSUE -> next cycle all outputs 0; start 2 cycles later -> full normal run.
// - Address sequence, in_ready=1:
//   - s0 (a,b,tw) = (0,1,0) (2,3,0) (4,5,0) (6,7,0)
//   - s1 = (0,2,0) (1,3,2) (4,6,0) (5,7,2)
//   - s2 = (0,4,0) (1,5,1) (2,6,2) (3,7,3)
// - Timing: start pulse -> busy high 18 cycles, done pulse on cycle 19, rd_en high 12 cycles total.
//   - Each wr_en is exactly 2 cycles after its rd_en, with matching addresses.
// - Stall: in_ready=0 for 3 cycles during s1 k=2 -> k=2 reissued with (4,6,0); done delayed exactly 3 cycles.
// - Drain hazard: BFLY_LATENCY=4 -> no rd_en of stage s+1 before the last wr_en of stage s; gap = 4 cycles.
// - Ignored start: start held high through the run -> one transform, one done.
//   - The next transform begins only after IDLE is re-entered with start still high.
// - Golden model: N=32, random data with a behavioural butterfly model.
//   - RAM result matches a software FFT within +-2 LSB.

Source files
------------

// File: rtl/fft_stage_sequencer_if.sv
// Bus between the FFT stage sequencer and its RAM/ROM/butterfly datapath.
// Handshake: the sequencer issues a butterfly (rd_en=1) only in a cycle where
// i_in_ready=1. A cycle with i_in_ready=0 transfers nothing and may be retried.
// o_wr_en is a pure strobe with no back-pressure.
interface fft_stage_sequencer_if #(
  parameter int ADDR_W  = 5,
  parameter int STAGE_W = 4
);
  logic               i_start;
  logic               i_in_ready;
  logic               o_busy;
  logic               o_done;
  logic [STAGE_W-1:0] o_stage;
  logic               o_rd_en;
  logic [ADDR_W-1:0]  o_rd_addr_a;
  logic [ADDR_W-1:0]  o_rd_addr_b;
  logic [ADDR_W-2:0]  o_tw_addr;
  logic               o_wr_en;
  logic [ADDR_W-1:0]  o_wr_addr_a;
  logic [ADDR_W-1:0]  o_wr_addr_b;
  logic [1:0]         o_dbg_state;

  modport master (
    input  i_start, i_in_ready,
    output o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b,
           o_tw_addr, o_wr_en, o_wr_addr_a, o_wr_addr_b, o_dbg_state
  );

  modport slave (
    output i_start, i_in_ready,
    input  o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b,
           o_tw_addr, o_wr_en, o_wr_addr_a, o_wr_addr_b, o_dbg_state
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT sharing one
// pipelined butterfly. It issues read/twiddle addresses and delayed write-backs.
module fft_stage_sequencer #(
  parameter int BUFFER_SIZE  = 32,
  parameter int BFLY_LATENCY = 2,
  parameter int ADDR_W       = $clog2(BUFFER_SIZE),
  parameter int STAGE_W      = $clog2(ADDR_W) + 1
) (
  input logic                 i_clk,
  input logic                 i_rst,
  fft_stage_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0]       K_LAST = ADDR_W'(BUFFER_SIZE / 2 - 1);
  localparam logic [STAGE_W-1:0]      S_LAST = STAGE_W'(ADDR_W - 1);
  // Pipe slots older than the output slot; the output slot writes this cycle.
  localparam logic [BFLY_LATENCY-1:0] INFLIGHT_MASK = BFLY_LATENCY'((1 << (BFLY_LATENCY - 1)) - 1);

  state_t                  r_state, w_next;
  logic [ADDR_W-1:0]       r_k;
  logic [STAGE_W-1:0]      r_s;
  logic [BFLY_LATENCY-1:0] r_pv;
  logic [ADDR_W-1:0]       r_pa [BFLY_LATENCY];
  logic [ADDR_W-1:0]       r_pb [BFLY_LATENCY];

  logic              w_rd_en, w_last_issue, w_drained;
  logic [ADDR_W-1:0] w_span, w_pos, w_addr_a, w_addr_b;
  logic [ADDR_W-2:0] w_tw;

  assign w_rd_en      = (r_state == S_ISSUE) && bus.i_in_ready;
  assign w_last_issue = w_rd_en && (r_k == K_LAST);
  assign w_drained    = ~|(r_pv & INFLIGHT_MASK);

  always_comb begin
    w_span   = ADDR_W'(1) << r_s;
    w_pos    = r_k & (w_span - ADDR_W'(1));
    w_addr_a = ((r_k >> r_s) << (r_s + STAGE_W'(1))) | w_pos;
    w_addr_b = w_addr_a + w_span;
    w_tw     = (ADDR_W-1)'(w_pos << (STAGE_W'(ADDR_W - 1) - r_s));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_ISSUE;
      S_ISSUE: if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (w_drained) w_next = (r_s == S_LAST) ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy      = 1'b0;
    bus.o_done      = 1'b0;
    bus.o_stage     = '0;
    bus.o_rd_en     = w_rd_en;
    bus.o_rd_addr_a = '0;
    bus.o_rd_addr_b = '0;
    bus.o_tw_addr   = '0;
    bus.o_wr_en     = r_pv[BFLY_LATENCY-1];
    bus.o_wr_addr_a = r_pa[BFLY_LATENCY-1];
    bus.o_wr_addr_b = r_pb[BFLY_LATENCY-1];
    bus.o_dbg_state = r_state;
    unique case (r_state)
      S_ISSUE: begin
        bus.o_busy      = 1'b1;
        bus.o_stage     = r_s;
        bus.o_rd_addr_a = w_addr_a;
        bus.o_rd_addr_b = w_addr_b;
        bus.o_tw_addr   = w_tw;
      end
      S_DRAIN: begin
        bus.o_busy  = 1'b1;
        bus.o_stage = r_s;
      end
      S_DONE: begin
        bus.o_done  = 1'b1;
        bus.o_stage = r_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k <= '0;
      r_s <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_k <= '0;
          r_s <= '0;
        end
        S_ISSUE: if (w_rd_en) r_k <= w_last_issue ? '0 : r_k + ADDR_W'(1);
        S_DRAIN: if (w_drained && (r_s != S_LAST)) begin
          r_s <= r_s + STAGE_W'(1);
          r_k <= '0;
        end
        default: ;
      endcase
    end
  end

  // Write-back pipe: zero addresses travel with bubbles so idle outputs read 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pv <= '0;
      for (int i = 0; i < BFLY_LATENCY; i++) begin
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_en;
      r_pa[0] <= w_rd_en ? w_addr_a : '0;
      r_pb[0] <= w_rd_en ? w_addr_b : '0;
      for (int i = 1; i < BFLY_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: N=8 with latency 2 (main) and latency 4 (drain).
module tb_fft_stage_sequencer;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;

  // {stage, a, b, tw}
  logic [10:0] exp_q[$];
  // {cycle[15:0], stage, a, b}
  logic [24:0] wr_q[$];
  logic [24:0] q4[$];

  fft_stage_sequencer_if #(.ADDR_W(AW), .STAGE_W(SW)) bus ();
  fft_stage_sequencer_if #(.ADDR_W(AW), .STAGE_W(SW)) bus4 ();

  fft_stage_sequencer #(.BUFFER_SIZE(N), .BFLY_LATENCY(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  fft_stage_sequencer #(.BUFFER_SIZE(N), .BFLY_LATENCY(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .bus(bus4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] outs();
    return {bus.o_busy, bus.o_done, bus.o_stage, bus.o_rd_en, bus.o_rd_addr_a,
            bus.o_rd_addr_b, bus.o_tw_addr, bus.o_wr_en, bus.o_wr_addr_a, bus.o_wr_addr_b};
  endfunction

  // Textbook DIT loop nest: groups of 2*span, twiddle exponent j*N/(2*span).
  task automatic fill_exp();
    int span, a, b, tw;
    for (int s = 0; s < AW; s++) begin
      span = 1 << s;
      for (int base = 0; base < N; base += 2 * span)
        for (int j = 0; j < span; j++) begin
          a  = base + j;
          b  = a + span;
          tw = j * (N / (2 * span));
          exp_q.push_back({3'(s), 3'(a), 3'(b), 2'(tw)});
        end
    end
  endtask

  // Scoreboard for the latency-2 instance.
  always @(negedge clk) begin
    logic [24:0] ent;
    logic [10:0] e;
    bit haz;
    if (!rst) begin
      if (bus.o_done) done_cnt++;
      if (bus.o_wr_en) begin
        chk("wr_has_issue", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          ent = wr_q.pop_front();
          chk("wr_addr_and_delay", {ent[5:0], 16'(cyc)}, {bus.o_wr_addr_a, bus.o_wr_addr_b, ent[24:9] + 16'd2});
        end
      end
      if (bus.o_rd_en) begin
        rd_cnt++;
        haz = 1'b0;
        foreach (wr_q[i]) if (wr_q[i][8:6] < bus.o_stage) haz = 1'b1;
        chk("rd_before_prev_stage_written", 32'(haz), 32'd0);
        chk("rd_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rd_stage_a_b_tw", {bus.o_stage, bus.o_rd_addr_a, bus.o_rd_addr_b, bus.o_tw_addr}, e);
        end
        wr_q.push_back({16'(cyc), bus.o_stage, bus.o_rd_addr_a, bus.o_rd_addr_b});
      end
    end
  end

  // mode 0: always ready, 1: random ready, 2: 3 stall cycles at stage 1 k=2.
  task automatic run(input int mode, input bit hold);
    int m_left, m_stg, m_drain, stalls, forced, done_n, rd0, dn0;
    bit m_fin, rdy, exp_busy, exp_done;
    fill_exp();
    rd0 = rd_cnt;
    dn0 = done_cnt;
    bus.i_start = 1'b1;
    bus.i_in_ready = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.i_start = 1'b0;
    m_left = N / 2; m_stg = 0; m_drain = 0; m_fin = 1'b0;
    stalls = 0; forced = 0; done_n = 0;
    for (int n = 1; n <= 200 && done_n == 0; n++) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(m_stg == 1 && m_left == 2 && forced < 3);
          if (!rdy) forced++;
        end
      endcase
      bus.i_in_ready = rdy;
      exp_done = m_fin;
      exp_busy = !m_fin;
      if (!m_fin) begin
        if (m_left > 0) begin
          if (rdy) begin
            m_left--;
            if (m_left == 0) m_drain = 2;
          end else stalls++;
        end else begin
          m_drain--;
          if (m_drain == 0) begin
            if (m_stg < AW - 1) begin
              m_stg++;
              m_left = N / 2;
            end else m_fin = 1'b1;
          end
        end
      end
      @(negedge clk);
      chk("busy_done_timeline", {bus.o_busy, bus.o_done}, {exp_busy, exp_done});
      if (bus.o_done) done_n = n;
      @(posedge clk); #1;
    end
    bus.i_in_ready = 1'b1;
    chk("done_cycle", done_n, 19 + stalls);
    chk("one_done_pulse", done_cnt - dn0, 1);
    chk("rd_en_count", rd_cnt - rd0, 12);
    chk("all_issued", exp_q.size(), 0);
    chk("all_written", wr_q.size(), 0);
  endtask

  initial begin
    int done_n, rd4, busy4, dn4;
    int first_rd[AW], last_rd[AW], last_wr[AW];
    logic [24:0] ent;
    bus.i_start = 1'b0;
    bus.i_in_ready = 1'b1;
    bus4.i_start = 1'b0;
    bus4.i_in_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    chk("reset_stage4_outputs", {bus4.o_busy, bus4.o_rd_en, bus4.o_wr_en}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", outs(), 0);
    @(posedge clk); #1;

    run(0, 1'b0);
    run(1, 1'b0);
    run(1, 1'b0);
    run(2, 1'b0);

    // Start held high: DONE ignores it, the following IDLE cycle accepts it.
    run(0, 1'b1);
    fill_exp();
    @(negedge clk);
    chk("idle_between_runs", {bus.o_busy, bus.o_done}, 2'b00);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("restart_busy", bus.o_busy, 1);
    done_n = 0;
    for (int n = 0; n < 100 && done_n == 0; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.o_done) done_n = n + 2;
    end
    chk("restart_done_cycle", done_n, 19);
    chk("restart_all_issued", exp_q.size(), 0);
    @(posedge clk); #1;

    // Reset in the middle of stage 0.
    fill_exp();
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", outs(), 0);
    exp_q.delete();
    wr_q.delete();
    @(negedge clk);
    chk("reset_next_cycle_outputs", outs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run(0, 1'b0);

    // Latency-4 instance: drain spacing and write-back delay.
    for (int s = 0; s < AW; s++) begin
      first_rd[s] = -1; last_rd[s] = -1; last_wr[s] = -1;
    end
    rd4 = 0; busy4 = 0; dn4 = 0; done_n = 0;
    bus4.i_start = 1'b1;
    @(posedge clk); #1;
    bus4.i_start = 1'b0;
    for (int n = 1; n <= 100 && done_n == 0; n++) begin
      @(negedge clk);
      if (bus4.o_busy) busy4++;
      if (bus4.o_done) done_n = n;
      if (bus4.o_wr_en) begin
        chk("lat4_wr_has_issue", 32'(q4.size() > 0), 32'd1);
        if (q4.size() > 0) begin
          ent = q4.pop_front();
          chk("lat4_wr_addr_and_delay", {ent[5:0], 16'(n)}, {bus4.o_wr_addr_a, bus4.o_wr_addr_b, ent[24:9] + 16'd4});
          last_wr[ent[8:6]] = n;
        end
      end
      if (bus4.o_rd_en) begin
        rd4++;
        if (first_rd[bus4.o_stage] < 0) first_rd[bus4.o_stage] = n;
        last_rd[bus4.o_stage] = n;
        q4.push_back({16'(n), bus4.o_stage, bus4.o_rd_addr_a, bus4.o_rd_addr_b});
      end
      @(posedge clk); #1;
    end
    chk("lat4_rd_count", rd4, 12);
    chk("lat4_busy_cycles", busy4, 3 * (N / 2 + 4));
    chk("lat4_done_cycle", done_n, 3 * (N / 2 + 4) + 1);
    for (int s = 0; s < AW - 1; s++) begin
      chk("lat4_no_early_read", 32'(first_rd[s+1] > last_wr[s]), 32'd1);
      chk("lat4_stage_gap", first_rd[s+1] - last_rd[s], 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
